sar_value_finder: RTL and testbench
===================================

Name: sar_value_finder

Overview:
- Successive-approximation search engine that determines an unknown operand `a` without reading it.
- Drives candidate values into a magnitude comparator's `b` side and `mode` pin, and uses only the comparator's single-bit "a > b" answer.
- Supports unsigned and two's-complement signed search.
- Sits on the other end of the dual-mode comparator interface: it produces the probe and consumes the greater-than flag.

Parameters:
- WIDTH, 8, operand width in bits (>= 2).

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- start, input, 1, request a search; sampled only in IDLE.
- mode_in, input, 1, 1 = signed search, 0 = unsigned; latched when start is accepted.
- gt_in, input, 1, comparator result "a > probe" under cmp_mode; combinational from probe/cmp_mode.
- probe, output, WIDTH, candidate driven to the comparator b operand; registered.
- cmp_mode, output, 1, mode driven to the comparator; registered copy of the latched mode_in.
- busy, output, 1, high while a search is in progress.
- done, output, 1, one-cycle pulse when result becomes valid.
- result, output, WIDTH, found value of a; held until the next accepted start.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE.
  - probe, cmp_mode, busy, done, result, and internal acc/bit index all 0.
  - Reset mid-search aborts immediately; no done pulse is produced.
- Search domain:
  - Work on a biased value u.
  - Unsigned: u = x.
  - Signed: u = x ^ (1 << (WIDTH-1)), so unsigned order of u equals signed order of x.
- Trial value: trial = acc | (1 << k), where k is the current bit index, counting WIDTH-1 down to 0.
- Probe encoding:
  - probe = D(trial - 1), where D is the inverse bias (identity for unsigned; XOR MSB for signed).
  - trial >= 1 always, so no underflow.
  - gt_in=1 means a >= D(trial), so bit k is kept.
- States:
  - IDLE: busy=0. On start=1, latch mode_in into cmp_mode, set acc=0 and k=WIDTH-1, load probe for the first trial, then go to SEARCH.
  - SEARCH: busy=1. Each edge samples gt_in for the probe currently driven.
    - If gt_in=1: acc <= trial.
    - If k>0: k <= k-1 and probe is reloaded for the next trial.
    - If k==0: result <= D(final acc), done <= 1, go to DONE.
  - DONE: busy=0, done=1 for exactly this one cycle, then go to IDLE unconditionally.
- Timing:
  - Start accepted at edge E.
  - gt_in is sampled at edges E+1 .. E+WIDTH.
  - done is high in the cycle following edge E+WIDTH.
  - Throughput: one search per WIDTH+2 cycles.
- start while busy or in DONE is ignored and not queued.
- mode_in changes after acceptance have no effect on the running search.
- probe holds its last value in DONE and IDLE. result changes only on entering DONE.
- gt_in is never sampled in IDLE or DONE.

Optional Feature:
- Macro: SAR_REGISTERED_CMP_EN.
- Defined:
  - Adds one settle cycle after every probe update; gt_in is sampled only on the second edge.
  - A search takes 2*WIDTH SEARCH cycles, for a registered comparator.
  - A 1-bit phase flag is added; busy also covers the settle cycles.
- Undefined: single-cycle sampling as specified above.
- Result values are identical in both builds.

Test Plan:
- Unsigned a=0xB7, mode_in=0, start pulse -> busy high for 8 cycles, done 1 cycle, result=0xB7; first probe=0x7F.
- Signed a=0x80 (-128), mode_in=1 -> first probe=0xFF; every gt_in=0; result=0x80 after 8 sampling cycles.
- Boundaries, covering both modes:
  - unsigned a=0x00 -> 0x00; unsigned a=0xFF -> 0xFF, last probe 0xFE.
  - signed a=0x7F -> 0x7F; signed a=0xFF -> 0xFF.
- start re-asserted during SEARCH and mode_in toggled mid-search -> ignored; result matches the original mode; next start accepted only from IDLE.
- reset asserted at the 4th sampling edge -> all outputs 0 asynchronously, no done; fresh search with a=0x3C -> 0x3C.
- SAR_REGISTERED_CMP_EN build with a one-cycle-delayed comparator model, a=0x5A unsigned -> done 16 cycles after start edge, result=0x5A.

Source files
------------

// File: rtl/sar_value_finder.sv
// Successive-approximation finder: probes a comparator's b/mode pins and rebuilds a from the a>b flag.
// Latency WIDTH+2 cycles per search (2*WIDTH+2 with SAR_REGISTERED_CMP_EN); start is ignored, not queued, while busy/done.
module sar_value_finder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode_in,
  input  logic             gt_in,
  output logic [WIDTH-1:0] probe,
  output logic             cmp_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  acc;
  logic [KW-1:0]     k;
  logic [KW-1:0]     k_dec;
  logic [WIDTH-1:0]  trial;
  logic [WIDTH-1:0]  acc_next;
  logic [WIDTH-1:0]  probe_next;
  logic [WIDTH-1:0]  probe_first;
  logic [WIDTH-1:0]  result_next;
  logic              sample_now;
`ifdef SAR_REGISTERED_CMP_EN
  logic              phase;
`endif

  // The search runs on biased u so signed order becomes unsigned order; unbias maps back.
  function automatic logic [WIDTH-1:0] unbias(input logic [WIDTH-1:0] v, input logic s);
    return s ? (v ^ MSB) : v;
  endfunction

  always_comb begin
    trial       = acc | (ONE << k);
    acc_next    = gt_in ? trial : acc;
    k_dec       = k - KW'(1);
    probe_next  = unbias((acc_next | (ONE << k_dec)) - ONE, cmp_mode);
    probe_first = unbias(MSB - ONE, mode_in);
    result_next = unbias(acc_next, cmp_mode);
`ifdef SAR_REGISTERED_CMP_EN
    sample_now  = phase;
`else
    sample_now  = 1'b1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      acc      <= '0;
      k        <= '0;
      probe    <= '0;
      cmp_mode <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
`ifdef SAR_REGISTERED_CMP_EN
      phase    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            cmp_mode <= mode_in;
            acc      <= '0;
            k        <= KW'(WIDTH-1);
            probe    <= probe_first;
            busy     <= 1'b1;
            state    <= S_SEARCH;
`ifdef SAR_REGISTERED_CMP_EN
            phase    <= 1'b0;
`endif
          end
        end
        S_SEARCH: begin
`ifdef SAR_REGISTERED_CMP_EN
          // First cycle after a probe update lets the registered comparator settle.
          phase <= ~phase;
`endif
          if (sample_now) begin
            acc <= acc_next;
            if (k != '0) begin
              k     <= k_dec;
              probe <= probe_next;
            end else begin
              result <= result_next;
              done   <= 1'b1;
              busy   <= 1'b0;
              state  <= S_DONE;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_value_finder.sv
// Directed bench for sar_value_finder: a behavioural comparator answers the probes and each search is scored against hand-computed values.
module tb_sar_value_finder;

  localparam int W = 8;
`ifdef SAR_REGISTERED_CMP_EN
  localparam int LAT = 2 * W;
`else
  localparam int LAT = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         mode_in = 1'b0;
  logic         gt_in;
  logic [W-1:0] probe;
  logic         cmp_mode;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic [W-1:0] a_val = '0;
  logic         gt_model;

  int checks = 0;
  int failures = 0;

  sar_value_finder #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .mode_in  (mode_in),
    .gt_in    (gt_in),
    .probe    (probe),
    .cmp_mode (cmp_mode),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  assign gt_model = cmp_mode ? ($signed(a_val) > $signed(probe)) : (a_val > probe);

`ifdef SAR_REGISTERED_CMP_EN
  logic gt_q;
  always @(posedge clk or posedge reset) begin
    if (reset) gt_q <= 1'b0;
    else       gt_q <= gt_model;
  end
  assign gt_in = gt_q;
`else
  assign gt_in = gt_model;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // One full search: start pulse, then score first/last probe, busy length, latency, result, done width.
  task automatic run_search(input logic m, input logic [W-1:0] av,
                            input logic [W-1:0] exp_first, input logic [W-1:0] exp_last,
                            input string tag);
    int n = 0;
    int busy_cnt;
    logic [W-1:0] lastp;
    bit got = 0;
    @(negedge clk);
    a_val = av; mode_in = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, "_first_probe"}, 32'(probe), 32'(exp_first));
    chk({tag, "_cmp_mode"}, 32'(cmp_mode), 32'(m));
    busy_cnt = busy ? 1 : 0;
    lastp = probe;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1; n = i;
      end else begin
        if (busy) busy_cnt++;
        lastp = probe;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(n), 32'(LAT));
    chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(LAT));
    chk({tag, "_result"}, 32'(result), 32'(av));
    chk({tag, "_last_probe"}, 32'(lastp), 32'(exp_last));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  typedef struct {
    logic         mode;
    logic [W-1:0] a;
    logic [W-1:0] first;
    logic [W-1:0] last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int bad_mode;
    bit got;
    bit saw_done;

    vecs[0] = '{1'b0, 8'hB7, 8'h7F, 8'hB6};
    vecs[1] = '{1'b1, 8'h80, 8'hFF, 8'h80};
    vecs[2] = '{1'b0, 8'h00, 8'h7F, 8'h00};
    vecs[3] = '{1'b0, 8'hFF, 8'h7F, 8'hFE};
    vecs[4] = '{1'b1, 8'h7F, 8'hFF, 8'h7E};
    vecs[5] = '{1'b1, 8'hFF, 8'hFF, 8'hFE};
    vecs[6] = '{1'b1, 8'h01, 8'hFF, 8'h00};
    vecs[7] = '{1'b0, 8'h5A, 8'h7F, 8'h5A};
    vecs[8] = '{1'b1, 8'hB7, 8'hFF, 8'hB6};

    #1 reset = 1'b1;
    #12;
    chk("rst_probe", 32'(probe), 32'd0);
    chk("rst_cmp_mode", 32'(cmp_mode), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 9; v++)
      run_search(vecs[v].mode, vecs[v].a, vecs[v].first, vecs[v].last, $sformatf("vec%0d", v));

    // start held high and mode_in toggling during a search must not disturb it.
    @(negedge clk);
    a_val = 8'h90; mode_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("hold_busy_start", 32'(busy), 32'd1);
    bad_mode = 0; got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      mode_in = ~mode_in;
      @(posedge clk); #1;
      if (cmp_mode !== 1'b0) bad_mode++;
      if (done) got = 1;
    end
    chk("hold_done_seen", 32'(got), 32'd1);
    chk("hold_cmp_mode_stable", 32'(bad_mode), 32'd0);
    chk("hold_result", 32'(result), 32'h90);
    @(negedge clk);
    mode_in = 1'b1;
    @(posedge clk); #1;
    chk("hold_ignored_in_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("hold_accept_in_idle", 32'(busy), 32'd1);
    chk("hold_new_mode", 32'(cmp_mode), 32'd1);
    start = 1'b0;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    chk("hold2_done_seen", 32'(got), 32'd1);
    chk("hold2_result", 32'(result), 32'h90);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a signed search.
    @(negedge clk);
    a_val = 8'h80; mode_in = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_probe", 32'(probe), 32'd0);
    chk("arst_cmp_mode", 32'(cmp_mode), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 2 * LAT + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1;
    end
    chk("arst_no_done", 32'(saw_done), 32'd0);
    run_search(1'b0, 8'h3C, 8'h7F, 8'h3C, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
